updslow_llr_to_fifo_packer: RTL and testbench
=============================================

Name: updslow_llr_to_fifo_packer

Overview:
Write-side counterpart of the slow-PHY-to-LLR unpacker. It takes the per-cycle RE stream and noise samples and packs them into 128-bit words for the IQ FIFO and the Noise FIFO. These are the FIFOs the unpacker later drains. Each word uses the same lane layout the unpacker expects, so a stream passed through both blocks returns unchanged. Operation is one user at a time: start pulse, then the ACTIVE packing phase, then a flush of any partial words, then a done pulse.

Parameters:
SAMPLE_W, 16, width of one I, Q or noise sample. Only 16 is supported; the 128-bit word layout depends on it.
CNT_W, 16, width of the RE amount and the RE counter.

Ports:
i_core_clk  in  1  core clock; all logic on rising edge
i_rx_rst  in  1  asynchronous, active-high reset
i_user_start  in  1  one-cycle pulse; starts a user (honoured in IDLE only)
i_cur_user_re_amounts  in  16  REs for this user; latched at start
i_data_strobe  in  1  RE beat valid (2 REs per beat)
i_re0_data_i / i_re0_data_q / i_re1_data_i / i_re1_data_q  in  16 each  beat samples
i_noise_strobe  in  1  noise sample valid
i_noise_data  in  16  noise sample
IQ_FIFO_Full  in  1  IQ FIFO full
Noise_FIFO_Full  in  1  Noise FIFO full
o_ready  out  1  beat and noise sample accepted this cycle if their strobe is high
IQ_FIFO_Write_Enable  out  1  write the IQ word
IQ_Data_SUM  out  128  IQ word
Noise_FIFO_Write_Enable  out  1  write the noise word
Noise_Data_SUM  out  128  noise word
o_busy  out  1  state != IDLE
o_user_done  out  1  one-cycle pulse at end of user
o_overflow  out  1  sticky: a strobe was dropped

Behaviour:
- Reset: state IDLE. All counters 0. Pending registers empty. Data words 0. All outputs 0.
- Reset mid-user: pending words are discarded and no write is issued.
- States: IDLE, ACTIVE, FLUSH, DRAIN, DONE.
  - IDLE to ACTIVE on i_user_start. On that edge: latch the RE amount; clear re_cnt, beat phase, noise lane and o_overflow.
  - i_user_start in any other state is ignored.
  - ACTIVE to FLUSH when re_cnt >= latched amount (registered compare). An amount of 0 goes to FLUSH on the first ACTIVE cycle.
  - FLUSH to DRAIN once partial words are loaded. If no partial exists, it moves on the first cycle the pending registers are empty.
  - DRAIN to DONE when both pending registers are empty.
  - DONE to IDLE after one cycle, with o_user_done=1 during DONE.
- o_ready = ACTIVE && re_cnt < amount && !(iq_pend && IQ_FIFO_Full) && !(noise_pend && Noise_FIFO_Full).
- IQ packing:
  - Each accepted beat adds 2 to re_cnt and toggles the beat phase.
  - Phase 0 fills bits [63:0] as re0_i[15:0], re0_q[31:16], re1_i[47:32], re1_q[63:48].
  - Phase 1 fills bits [127:64] with the same order offset by 64.
  - A phase-1 beat completes the word. The word moves to the IQ pending register on the next edge.
- Noise packing:
  - The accepted sample at lane k (0..7) goes to bits [16k+15:16k]. Lane 7 completes the word and the lane wraps to 0.
  - Noise is independent of beats. Both may be accepted in the same cycle.
- Pending registers are one-deep each.
  - Write_Enable = pend && !Full, combinational.
  - The pending register clears on the edge where Write_Enable=1.
  - Data_SUM holds the pending word, and holds its value while not pending.
  - Completing a word in the same cycle the old one is written: the new word loads and pend stays 1.
- Latency: Write_Enable rises 1 cycle after the completing strobe if the FIFO is not full.
- FLUSH partial words:
  - Odd beat phase: the IQ word is loaded with [127:64]=0.
  - Noise lane != 0: the noise word is loaded with unfilled lanes = 0.
  - Each partial is loaded only when its pending register is empty.
- Overflow: a strobe with o_ready=0 while ACTIVE sets o_overflow. The sample is dropped.
- Strobes outside ACTIVE are ignored silently and do not set overflow.
- re_cnt saturates at 16'hFFFF.

Test Plan:
1. Amount=8, 4 beats back-to-back, re0_i=beat*4+1, etc., 8 noise samples 0x10..0x17, FIFOs never full. Expect 2 IQ writes: word0[15:0]=1, word0[79:64]=5. Expect 1 noise write = {0x17,...,0x10}. o_user_done 1 cycle after the last write drains. o_overflow=0.
2. Amount=6 (3 beats), 3 noise samples. Expect the FLUSH IQ word with [127:64]=0. Expect the noise word with lanes 3..7 = 0. Exactly 2 IQ writes and 1 noise write.
3. IQ_FIFO_Full held high for 5 cycles while a word is pending. Expect no IQ write and o_ready=0 until Full drops. Expect a write the cycle Full=0 and data unchanged.
4. Strobe while o_ready=0. Expect o_overflow=1 and held until the next i_user_start. Expect the dropped beat absent from output words.
5. Amount=0. Expect ACTIVE, then FLUSH, DRAIN, DONE, with no writes and o_user_done pulse.
6. i_rx_rst asserted mid-user with a word pending and Full=1. Expect immediate zero outputs and no write after release. A new start behaves as in scenario 1.

Source files
------------

// File: rtl/updslow_llr_to_fifo_packer_if.sv
// Signal bundle between the RE/noise producer, the LLR FIFO packer and the IQ/Noise FIFOs.
// The master side drives the stream and FIFO status. The slave side is the packer.
interface updslow_llr_to_fifo_packer_if #(
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 16
);
  logic                  i_user_start;
  logic [CNT_W-1:0]      i_cur_user_re_amounts;
  logic                  i_data_strobe;
  logic [SAMPLE_W-1:0]   i_re0_data_i;
  logic [SAMPLE_W-1:0]   i_re0_data_q;
  logic [SAMPLE_W-1:0]   i_re1_data_i;
  logic [SAMPLE_W-1:0]   i_re1_data_q;
  logic                  i_noise_strobe;
  logic [SAMPLE_W-1:0]   i_noise_data;
  logic                  IQ_FIFO_Full;
  logic                  Noise_FIFO_Full;
  logic                  o_ready;
  logic                  IQ_FIFO_Write_Enable;
  logic [8*SAMPLE_W-1:0] IQ_Data_SUM;
  logic                  Noise_FIFO_Write_Enable;
  logic [8*SAMPLE_W-1:0] Noise_Data_SUM;
  logic                  o_busy;
  logic                  o_user_done;
  logic                  o_overflow;

  modport master (
    output i_user_start, i_cur_user_re_amounts, i_data_strobe,
           i_re0_data_i, i_re0_data_q, i_re1_data_i, i_re1_data_q,
           i_noise_strobe, i_noise_data, IQ_FIFO_Full, Noise_FIFO_Full,
    input  o_ready, IQ_FIFO_Write_Enable, IQ_Data_SUM,
           Noise_FIFO_Write_Enable, Noise_Data_SUM, o_busy, o_user_done, o_overflow
  );

  modport slave (
    input  i_user_start, i_cur_user_re_amounts, i_data_strobe,
           i_re0_data_i, i_re0_data_q, i_re1_data_i, i_re1_data_q,
           i_noise_strobe, i_noise_data, IQ_FIFO_Full, Noise_FIFO_Full,
    output o_ready, IQ_FIFO_Write_Enable, IQ_Data_SUM,
           Noise_FIFO_Write_Enable, Noise_Data_SUM, o_busy, o_user_done, o_overflow
  );
endinterface

// File: rtl/updslow_llr_to_fifo_packer.sv
// Packs the per-user RE beat stream and the noise samples into 128-bit IQ/Noise FIFO words.
// The lane layout is the one the slow-PHY-to-LLR unpacker expects.
module updslow_llr_to_fifo_packer #(
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 16
) (
  input logic                         i_core_clk,
  input logic                         i_rx_rst,
  updslow_llr_to_fifo_packer_if.slave bus
);
  localparam int BEAT_W = 4 * SAMPLE_W;
  localparam int WORD_W = 8 * SAMPLE_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_FLUSH, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      amount_q, amount_d, re_cnt_q, re_cnt_d;
  logic                  phase_q, phase_d;
  logic [2:0]            lane_q, lane_d;
  logic                  overflow_q, overflow_d;
  logic [BEAT_W-1:0]     iq_acc_q, iq_acc_d;
  logic [7*SAMPLE_W-1:0] noise_acc_q, noise_acc_d;
  logic                  iq_pend_q, iq_pend_d, noise_pend_q, noise_pend_d;
  logic [WORD_W-1:0]     iq_word_q, iq_word_d, noise_word_q, noise_word_d;

  logic                  active, ready, iq_we, noise_we, beat_take, noise_take;
  logic [BEAT_W-1:0]     beat;

  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.i_user_start) state_d = S_ACTIVE;
      S_ACTIVE: if (re_cnt_q >= amount_q) state_d = S_FLUSH;
      S_FLUSH:  if (!iq_pend_q && !noise_pend_q) state_d = S_DRAIN;
      S_DRAIN:  if (!iq_pend_q && !noise_pend_q) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // A full FIFO only stalls the stream when its pending word cannot leave this cycle.
  always_comb begin
    active   = (state_q == S_ACTIVE);
    iq_we    = iq_pend_q && !bus.IQ_FIFO_Full;
    noise_we = noise_pend_q && !bus.Noise_FIFO_Full;
    ready    = active && (re_cnt_q < amount_q)
               && !(iq_pend_q && bus.IQ_FIFO_Full)
               && !(noise_pend_q && bus.Noise_FIFO_Full);
    bus.o_ready                 = ready;
    bus.IQ_FIFO_Write_Enable    = iq_we;
    bus.IQ_Data_SUM             = iq_word_q;
    bus.Noise_FIFO_Write_Enable = noise_we;
    bus.Noise_Data_SUM          = noise_word_q;
    bus.o_busy                  = (state_q != S_IDLE);
    bus.o_user_done             = (state_q == S_DONE);
    bus.o_overflow              = overflow_q;
  end

  always_comb begin
    amount_d     = amount_q;
    re_cnt_d     = re_cnt_q;
    phase_d      = phase_q;
    lane_d       = lane_q;
    overflow_d   = overflow_q;
    iq_acc_d     = iq_acc_q;
    noise_acc_d  = noise_acc_q;
    iq_pend_d    = iq_pend_q && !iq_we;
    noise_pend_d = noise_pend_q && !noise_we;
    iq_word_d    = iq_word_q;
    noise_word_d = noise_word_q;
    beat         = {bus.i_re1_data_q, bus.i_re1_data_i, bus.i_re0_data_q, bus.i_re0_data_i};
    beat_take    = ready && bus.i_data_strobe;
    noise_take   = ready && bus.i_noise_strobe;

    if (state_q == S_IDLE && bus.i_user_start) begin
      amount_d    = bus.i_cur_user_re_amounts;
      re_cnt_d    = '0;
      phase_d     = 1'b0;
      lane_d      = 3'd0;
      overflow_d  = 1'b0;
      noise_acc_d = '0;
    end

    if (active && !ready && (bus.i_data_strobe || bus.i_noise_strobe))
      overflow_d = 1'b1;

    if (beat_take) begin
      re_cnt_d = (re_cnt_q >= CNT_MAX - CNT_W'(1)) ? CNT_MAX : re_cnt_q + CNT_W'(2);
      phase_d  = !phase_q;
      if (!phase_q) begin
        iq_acc_d = beat;
      end else begin
        iq_word_d = {beat, iq_acc_q};
        iq_pend_d = 1'b1;
      end
    end

    // Lanes 0..6 collect in the accumulator; lane 7 completes the word directly.
    if (noise_take) begin
      lane_d = lane_q + 3'd1;
      if (lane_q == 3'd7) begin
        noise_word_d = {bus.i_noise_data, noise_acc_q};
        noise_pend_d = 1'b1;
        noise_acc_d  = '0;
      end else begin
        for (int k = 0; k < 7; k++)
          if (lane_q == 3'(k)) noise_acc_d[k*SAMPLE_W +: SAMPLE_W] = bus.i_noise_data;
      end
    end

    if (state_q == S_FLUSH) begin
      if (phase_q && !iq_pend_q) begin
        iq_word_d = {{BEAT_W{1'b0}}, iq_acc_q};
        iq_pend_d = 1'b1;
        phase_d   = 1'b0;
      end
      if (lane_q != 3'd0 && !noise_pend_q) begin
        noise_word_d = {{SAMPLE_W{1'b0}}, noise_acc_q};
        noise_pend_d = 1'b1;
        noise_acc_d  = '0;
        lane_d       = 3'd0;
      end
    end
  end

  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      amount_q     <= '0;
      re_cnt_q     <= '0;
      phase_q      <= 1'b0;
      lane_q       <= 3'd0;
      overflow_q   <= 1'b0;
      iq_acc_q     <= '0;
      noise_acc_q  <= '0;
      iq_pend_q    <= 1'b0;
      noise_pend_q <= 1'b0;
      iq_word_q    <= '0;
      noise_word_q <= '0;
    end else begin
      amount_q     <= amount_d;
      re_cnt_q     <= re_cnt_d;
      phase_q      <= phase_d;
      lane_q       <= lane_d;
      overflow_q   <= overflow_d;
      iq_acc_q     <= iq_acc_d;
      noise_acc_q  <= noise_acc_d;
      iq_pend_q    <= iq_pend_d;
      noise_pend_q <= noise_pend_d;
      iq_word_q    <= iq_word_d;
      noise_word_q <= noise_word_d;
    end
  end
endmodule

// File: tb/tb_updslow_llr_to_fifo_packer.sv
// Self-checking bench for the LLR FIFO packer: directed scenarios plus randomized users
// compared against a queue-based model of the expected FIFO words.
module tb_updslow_llr_to_fifo_packer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  updslow_llr_to_fifo_packer_if bus ();
  updslow_llr_to_fifo_packer dut (.i_core_clk(clk), .i_rx_rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [127:0] iq_obs[$];
  logic [127:0] noise_obs[$];
  time last_wr_t = 0;

  always @(negedge clk) begin
    if (bus.IQ_FIFO_Write_Enable === 1'b1) begin
      iq_obs.push_back(bus.IQ_Data_SUM);
      last_wr_t = $time;
    end
    if (bus.Noise_FIFO_Write_Enable === 1'b1) begin
      noise_obs.push_back(bus.Noise_Data_SUM);
      last_wr_t = $time;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_beat(input logic strobe, input logic [63:0] b);
    bus.i_data_strobe = strobe;
    {bus.i_re1_data_q, bus.i_re1_data_i, bus.i_re0_data_q, bus.i_re0_data_i} = b;
  endtask

  task automatic start_user(input int amt);
    bus.i_cur_user_re_amounts = 16'(amt);
    bus.i_user_start = 1'b1;
    step();
    bus.i_user_start = 1'b0;
  endtask

  task automatic clear_obs();
    iq_obs.delete();
    noise_obs.delete();
    last_wr_t = 0;
  endtask

  task automatic wait_done(output int done_cnt);
    done_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.o_user_done === 1'b1) done_cnt++;
      else if (done_cnt > 0) break;
    end
    chk("done_pulse_count", 128'(done_cnt), 128'd1);
    chk("idle_after_done", {127'd0, bus.o_busy}, 128'd0);
  endtask

  // mode 0: random strobes, 1: four beats after eight noise starts, 2: beats+noise for 3 cycles
  task automatic run_user(input int amt, input int mode);
    logic [63:0]  beats[$];
    logic [15:0]  noises[$];
    logic [127:0] w;
    int cnt, cyc, done_cnt, nb, nn;
    time wr_t;
    cnt = 0;
    cyc = 0;
    clear_obs();
    start_user(amt);
    while (cnt < amt) begin
      logic ds, ns;
      logic [63:0] b;
      logic [15:0] n;
      if (mode == 1) begin
        ds = (cyc >= 4);
        ns = (cyc < 8);
        nb = beats.size();
        b  = {16'(nb*4+4), 16'(nb*4+3), 16'(nb*4+2), 16'(nb*4+1)};
        n  = 16'(16 + cyc);
      end else if (mode == 2) begin
        ds = 1'b1;
        ns = (cyc < 3);
        b  = {$urandom, $urandom};
        n  = 16'($urandom);
      end else begin
        ds = 1'($urandom_range(0, 1));
        ns = 1'($urandom_range(0, 1));
        b  = {$urandom, $urandom};
        n  = 16'($urandom);
      end
      set_beat(ds, b);
      bus.i_noise_strobe = ns;
      bus.i_noise_data   = n;
      @(negedge clk);
      chk("ready_in_window", {127'd0, bus.o_ready}, 128'd1);
      if (ds) begin
        beats.push_back(b);
        cnt += 2;
      end
      if (ns) noises.push_back(n);
      step();
      cyc++;
    end
    set_beat(1'b0, 64'd0);
    bus.i_noise_strobe = 1'b0;
    @(negedge clk);
    chk("ready_after_amount", {127'd0, bus.o_ready}, 128'd0);
    wait_done(done_cnt);
    wr_t = last_wr_t;

    nb = (beats.size() + 1) / 2;
    nn = (noises.size() + 7) / 8;
    chk("iq_write_count", 128'(iq_obs.size()), 128'(nb));
    chk("noise_write_count", 128'(noise_obs.size()), 128'(nn));
    for (int i = 0; i < nb; i++) begin
      w = '0;
      w[63:0] = beats[2*i];
      if (2*i + 1 < beats.size()) w[127:64] = beats[2*i+1];
      if (i < iq_obs.size()) chk("iq_word", iq_obs[i], w);
    end
    for (int i = 0; i < nn; i++) begin
      w = '0;
      for (int l = 0; l < 8; l++)
        if (8*i + l < noises.size()) w[16*l +: 16] = noises[8*i+l];
      if (i < noise_obs.size()) chk("noise_word", noise_obs[i], w);
    end
    chk("no_overflow", {127'd0, bus.o_overflow}, 128'd0);
    if (nb + nn > 0) chk("done_after_last_write", {127'd0, ($time > wr_t)}, 128'd1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    chk("rst_ready", {127'd0, bus.o_ready}, 128'd0);
    chk("rst_iq_we", {127'd0, bus.IQ_FIFO_Write_Enable}, 128'd0);
    chk("rst_noise_we", {127'd0, bus.Noise_FIFO_Write_Enable}, 128'd0);
    chk("rst_iq_data", bus.IQ_Data_SUM, 128'd0);
    chk("rst_noise_data", bus.Noise_Data_SUM, 128'd0);
    chk("rst_busy", {127'd0, bus.o_busy}, 128'd0);
    chk("rst_done", {127'd0, bus.o_user_done}, 128'd0);
    chk("rst_overflow", {127'd0, bus.o_overflow}, 128'd0);
    rst = 1'b0;
    step();
  endtask

  task automatic test_idle_strobes();
    clear_obs();
    set_beat(1'b1, 64'h1111_2222_3333_4444);
    bus.i_noise_strobe = 1'b1;
    repeat (10) step();
    set_beat(1'b0, 64'd0);
    bus.i_noise_strobe = 1'b0;
    step();
    chk("idle_strobe_overflow", {127'd0, bus.o_overflow}, 128'd0);
    chk("idle_strobe_busy", {127'd0, bus.o_busy}, 128'd0);
    chk("idle_strobe_writes", 128'(iq_obs.size() + noise_obs.size()), 128'd0);
  endtask

  task automatic test_basic();
    logic [127:0] w, nexp;
    int n;
    run_user(8, 1);
    n = iq_obs.size();
    chk("basic_iq_count", 128'(n), 128'd2);
    if (n > 0) begin
      w = iq_obs[0];
      chk("basic_w0_lane0", {112'd0, w[15:0]}, 128'd1);
      chk("basic_w0_lane4", {112'd0, w[79:64]}, 128'd5);
    end
    for (int l = 0; l < 8; l++) nexp[16*l +: 16] = 16'(16 + l);
    if (noise_obs.size() > 0) chk("basic_noise_word", noise_obs[0], nexp);
  endtask

  task automatic test_flush();
    logic [127:0] w;
    run_user(6, 2);
    if (iq_obs.size() > 1) begin
      w = iq_obs[1];
      chk("flush_iq_upper_zero", {64'd0, w[127:64]}, 128'd0);
    end
    if (noise_obs.size() > 0) begin
      w = noise_obs[0];
      chk("flush_noise_upper_zero", {48'd0, w[127:48]}, 128'd0);
    end
  endtask

  task automatic test_iq_full();
    logic [63:0] a, b, c, d;
    int done_cnt;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    c = {$urandom, $urandom}; d = {$urandom, $urandom};
    clear_obs();
    bus.IQ_FIFO_Full = 1'b1;
    start_user(8);
    set_beat(1'b1, a); step();
    set_beat(1'b1, b); step();
    set_beat(1'b0, 64'd0);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        bus.i_cur_user_re_amounts = 16'd2;
        bus.i_user_start = 1'b1;
      end
      @(negedge clk);
      chk("full_no_write", {127'd0, bus.IQ_FIFO_Write_Enable}, 128'd0);
      chk("full_not_ready", {127'd0, bus.o_ready}, 128'd0);
      chk("full_data_held", bus.IQ_Data_SUM, {b, a});
      step();
      bus.i_user_start = 1'b0;
    end
    bus.IQ_FIFO_Full = 1'b0;
    @(negedge clk);
    chk("full_release_write", {127'd0, bus.IQ_FIFO_Write_Enable}, 128'd1);
    chk("full_release_data", bus.IQ_Data_SUM, {b, a});
    chk("full_release_ready", {127'd0, bus.o_ready}, 128'd1);
    step();
    set_beat(1'b1, c); step();
    set_beat(1'b1, d); step();
    set_beat(1'b0, 64'd0);
    wait_done(done_cnt);
    chk("full_iq_count", 128'(iq_obs.size()), 128'd2);
    if (iq_obs.size() > 1) chk("full_second_word", iq_obs[1], {d, c});
    chk("full_no_overflow", {127'd0, bus.o_overflow}, 128'd0);
  endtask

  task automatic test_overflow();
    logic [63:0] a, b, x, c, d;
    int done_cnt;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; x = {$urandom, $urandom};
    c = {$urandom, $urandom}; d = {$urandom, $urandom};
    clear_obs();
    bus.IQ_FIFO_Full = 1'b1;
    start_user(8);
    set_beat(1'b1, a); step();
    set_beat(1'b1, b); step();
    set_beat(1'b1, x);
    @(negedge clk);
    chk("ovf_not_ready", {127'd0, bus.o_ready}, 128'd0);
    step();
    set_beat(1'b0, 64'd0);
    @(negedge clk);
    chk("ovf_set", {127'd0, bus.o_overflow}, 128'd1);
    step();
    bus.IQ_FIFO_Full = 1'b0;
    set_beat(1'b1, c); step();
    set_beat(1'b1, d); step();
    set_beat(1'b0, 64'd0);
    wait_done(done_cnt);
    chk("ovf_iq_count", 128'(iq_obs.size()), 128'd2);
    if (iq_obs.size() > 0) chk("ovf_word0", iq_obs[0], {b, a});
    if (iq_obs.size() > 1) chk("ovf_word1", iq_obs[1], {d, c});
    chk("ovf_sticky", {127'd0, bus.o_overflow}, 128'd1);
  endtask

  task automatic test_reset_mid_user();
    clear_obs();
    bus.IQ_FIFO_Full = 1'b1;
    start_user(8);
    set_beat(1'b1, {$urandom, $urandom}); step();
    set_beat(1'b1, {$urandom, $urandom}); step();
    set_beat(1'b0, 64'd0);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_iq_data", bus.IQ_Data_SUM, 128'd0);
    chk("mid_rst_we", {127'd0, bus.IQ_FIFO_Write_Enable}, 128'd0);
    chk("mid_rst_busy", {127'd0, bus.o_busy}, 128'd0);
    bus.IQ_FIFO_Full = 1'b0;
    step();
    rst = 1'b0;
    repeat (5) step();
    chk("mid_rst_no_write", 128'(iq_obs.size() + noise_obs.size()), 128'd0);
    run_user(8, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_user_start = 1'b0;
    bus.i_cur_user_re_amounts = '0;
    set_beat(1'b0, 64'd0);
    bus.i_noise_strobe = 1'b0;
    bus.i_noise_data = '0;
    bus.IQ_FIFO_Full = 1'b0;
    bus.Noise_FIFO_Full = 1'b0;
    test_reset();
    test_idle_strobes();
    test_basic();
    test_flush();
    test_iq_full();
    test_overflow();
    run_user(0, 0);
    for (int i = 0; i < 6; i++) run_user(int'($urandom_range(0, 20)), 0);
    test_reset_mid_user();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
